timer_multi: RTL and testbench
==============================

Name: timer_multi

Overview:
- Multi-channel, runtime-programmable down-counting timer.
- Successor to the fixed-period single timer. Period comes from a per-channel input instead of a build-time constant.
- Each channel runs one-shot or periodic, can be stopped or retriggered, and shares one clock-enable tick.
- Used by the debounce, keypad-scan and display-refresh logic of the calculator, where several independent delays are needed at once.

Parameters:
- NUM_CH, 4, number of independent timer channels (1..16).
- COUNT_W, 24, width of the period value and of each channel counter.
- DEFAULT_PERIOD, 1_250_000, period used when load_val is 0 (25 ms at a 20 ns clock). Must fit in COUNT_W.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  global tick enable. Counting and command sampling happen only on clk edges where enable=1.
- start  in  NUM_CH  per-channel start/retrigger command. Level is sampled on enabled edges.
- stop  in  NUM_CH  per-channel abort command. Level is sampled on enabled edges.
- periodic  in  NUM_CH  per-channel mode, sampled with start: 1 = auto-reload, 0 = one-shot.
- load_val  in  NUM_CH*COUNT_W  per-channel period in enabled edges. Channel i occupies bits [i*COUNT_W +: COUNT_W]. Sampled with start.
- busy  out  NUM_CH  channel is in the RUNNING state.
- done  out  NUM_CH  registered one-clk-cycle pulse on channel expiry.
- remaining  out  NUM_CH*COUNT_W  current count value of each channel, same packing as load_val.

Behaviour:
- Reset (reset=1 at a clk edge, regardless of enable):
  - every channel goes IDLE.
  - count=0, period register=0, mode register=0.
  - busy=0, done=0, remaining=0.
  - Reset mid-run aborts without a done pulse.
- Effective period P:
  - P = load_val if load_val != 0.
  - P = DEFAULT_PERIOD if load_val == 0.
- Per-channel FSM states: IDLE, RUNNING. The expiry event is carried by the done register, not a separate state.
- IDLE:
  - On an enabled edge with start=1 and stop=0: latch P and mode, set count <= P-1, go to RUNNING.
  - Otherwise stay IDLE.
- RUNNING, on each enabled edge, evaluated in this priority order:
  1. stop=1: go to IDLE, count <= 0, no done pulse.
  2. count==0: expiry. done <= 1.
     - One-shot: go to IDLE.
     - Periodic: count <= latched P-1, stay RUNNING.
     - If start=1 on this same edge, the restart takes effect instead (new P and mode latched, count <= newP-1, RUNNING). done still pulses.
  3. start=1: retrigger. Latch new P and mode, count <= P-1, no done.
  4. Otherwise: count <= count-1.
- Latency: if start is sampled at enabled edge E0, done is asserted in the clk cycle after enabled edge E_P, i.e. exactly P enabled edges later. Periodic mode repeats every P enabled edges with no gap cycle.
- done timing:
  - High for exactly one clk cycle.
  - Cleared on the next clk edge even if enable=0 on that edge.
- enable=0:
  - All counts, states and latched values hold.
  - start and stop are ignored, not queued.
- Changing load_val or periodic while RUNNING has no effect until the next start.
- Arithmetic: unsigned. The count never underflows because the count==0 check has priority over decrement.
- busy = (state==RUNNING), combinational from the state register.
- remaining = count register.
- Channels are fully independent. Simultaneous expiries each pulse their own done bit.

Decomposition:
- Shared package (timer_pkg):
  - state encodings ST_IDLE=1'b0, ST_RUNNING=1'b1.
  - function effective_period(load_val, DEFAULT_PERIOD).
  - ms/us/ns-to-cycles conversion constants, so callers compute load_val and DEFAULT_PERIOD consistently.
- Sub-module timer_channel (COUNT_W, DEFAULT_PERIOD): one channel's FSM, counter, period/mode latch and done register.
- timer_multi is a generate loop of NUM_CH timer_channel instances plus the bus slicing.

Test Plan:
1. One-shot, P=3: reset, then enable=1, ch0 start pulse with load_val=3, periodic=0 -> busy high for 3 cycles; done[0] high in the 4th cycle after the start edge, for exactly 1 cycle; then busy=0 and remaining=0.
2. Periodic with gated enable: ch1 load_val=5, periodic=1, enable asserted every other cycle -> done[1] pulses every 10 clk cycles (5 enabled edges); busy stays 1. Stop at an enabled edge -> busy=0 and no further done.
3. Retrigger, load_val=0 default: DEFAULT_PERIOD overridden to 8, ch2 load_val=0 -> expiry after 8 enabled edges. Start again at count=3 -> no done; expiry 8 edges after the retrigger.
4. Collisions: start coincides with the expiry edge (periodic=0, new load_val=2) -> done pulses once and the channel expires again 2 edges later. Stop coincides with count==0 -> no done pulse.
5. Reset and freeze: assert reset while ch0..ch3 are running at mixed counts -> next cycle all busy=0, done=0, remaining=0. Hold enable=0 during a run -> remaining frozen and done never asserts.
6. Independence: all 4 channels started on the same edge with load_val=4 -> all done bits pulse together. load_val 2/3/4/5 -> each done bit fires on its own edge.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel timer: channel state encoding,
// the effective-period rule and time-to-cycle conversion constants.
package timer_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RUNNING = 1'b1
  } state_e;

  // Widest counter the period helper supports.
  localparam int unsigned MAX_COUNT_W   = 32;

  // Clock is 50 MHz (20 ns). Callers derive load_val / DEFAULT_PERIOD from these.
  localparam int unsigned NS_PER_CYCLE  = 20;
  localparam int unsigned CYCLES_PER_US = 1000 / NS_PER_CYCLE;
  localparam int unsigned CYCLES_PER_MS = 1000000 / NS_PER_CYCLE;

  // A zero load value selects the build-time default period.
  function automatic logic [31:0] effective_period(input logic [31:0] load_val,
                                                   input logic [31:0] default_period);
    logic [31:0] p;
    if (load_val != 32'd0) begin
      p = load_val;
    end else begin
      p = default_period;
    end
    return p;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One down-counting timer channel: IDLE/RUNNING FSM, counter, latched
// period and mode, and a one-cycle registered expiry pulse.
module timer_channel
  import timer_pkg::*;
#(
  parameter int unsigned COUNT_W        = 24,
  parameter int unsigned DEFAULT_PERIOD = 1_250_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               start,
  input  logic               stop,
  input  logic               periodic,
  input  logic [COUNT_W-1:0] load_val,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] remaining
);

  localparam logic [COUNT_W-1:0] ONE  = COUNT_W'(1);
  localparam logic [COUNT_W-1:0] ZERO = COUNT_W'(0);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [COUNT_W-1:0] r_count;
  logic [COUNT_W-1:0] w_count_nxt;
  logic [COUNT_W-1:0] r_period;
  logic [COUNT_W-1:0] w_period_nxt;
  logic               r_mode;
  logic               w_mode_nxt;
  logic               r_done;
  logic               w_done_nxt;
  logic [COUNT_W-1:0] w_eff_period;

  assign w_eff_period = COUNT_W'(effective_period(32'(load_val), 32'(DEFAULT_PERIOD)));

  // State, counter, latched period/mode and done pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_count  <= ZERO;
      r_period <= ZERO;
      r_mode   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_period <= w_period_nxt;
      r_mode   <= w_mode_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // Next-state logic; everything holds on non-enabled edges except done, which self-clears.
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_period_nxt = r_period;
    w_mode_nxt   = r_mode;
    w_done_nxt   = 1'b0;
    if (enable) begin
      case (r_state)
        ST_IDLE: begin
          if (start && !stop) begin
            w_period_nxt = w_eff_period;
            w_mode_nxt   = periodic;
            w_count_nxt  = w_eff_period - ONE;
            w_state_nxt  = ST_RUNNING;
          end else begin
            w_state_nxt  = ST_IDLE;
          end
        end
        ST_RUNNING: begin
          if (stop) begin
            // Abort wins over everything, including a pending expiry.
            w_state_nxt = ST_IDLE;
            w_count_nxt = ZERO;
          end else if (r_count == ZERO) begin
            w_done_nxt = 1'b1;
            if (start) begin
              // A restart on the expiry edge replaces the reload/stop decision.
              w_period_nxt = w_eff_period;
              w_mode_nxt   = periodic;
              w_count_nxt  = w_eff_period - ONE;
              w_state_nxt  = ST_RUNNING;
            end else if (r_mode) begin
              w_count_nxt  = r_period - ONE;
              w_state_nxt  = ST_RUNNING;
            end else begin
              w_state_nxt  = ST_IDLE;
            end
          end else if (start) begin
            w_period_nxt = w_eff_period;
            w_mode_nxt   = periodic;
            w_count_nxt  = w_eff_period - ONE;
          end else begin
            w_count_nxt  = r_count - ONE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_count_nxt = ZERO;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Outputs decoded straight from the registers.
  always_comb begin
    busy      = (r_state == ST_RUNNING);
    done      = r_done;
    remaining = r_count;
  end

endmodule

// File: rtl/timer_multi.sv
// Multi-channel programmable timer: NUM_CH independent channels sharing one
// clock-enable tick, with packed per-channel period and count buses.
module timer_multi #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned COUNT_W        = 24,
  parameter int unsigned DEFAULT_PERIOD = 1_250_000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_CH-1:0]         start,
  input  logic [NUM_CH-1:0]         stop,
  input  logic [NUM_CH-1:0]         periodic,
  input  logic [NUM_CH*COUNT_W-1:0] load_val,
  output logic [NUM_CH-1:0]         busy,
  output logic [NUM_CH-1:0]         done,
  output logic [NUM_CH*COUNT_W-1:0] remaining
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    timer_channel #(
      .COUNT_W        (COUNT_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .start     (start[g]),
      .stop      (stop[g]),
      .periodic  (periodic[g]),
      .load_val  (load_val[g*COUNT_W +: COUNT_W]),
      .busy      (busy[g]),
      .done      (done[g]),
      .remaining (remaining[g*COUNT_W +: COUNT_W])
    );
  end

endmodule

// File: tb/tb_timer_multi.sv
// Directed bench for timer_multi: expected expiry events (edge number and
// channel mask) are queued when a start is driven and matched against the
// done pulses seen by a monitor.
module tb_timer_multi;

  localparam int NCH = 4;
  localparam int CW  = 24;

  logic                clk;
  logic                reset;
  logic                enable;
  logic [NCH-1:0]      start;
  logic [NCH-1:0]      stop;
  logic [NCH-1:0]      periodic;
  logic [NCH*CW-1:0]   load_val;
  logic [NCH-1:0]      busy;
  logic [NCH-1:0]      done;
  logic [NCH*CW-1:0]   remaining;

  typedef struct packed {
    logic [31:0]    at;
    logic [NCH-1:0] mask;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         obs_q[$];
  int unsigned cyc    = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] e0;
  logic [31:0] e1;

  timer_multi #(
    .NUM_CH         (NCH),
    .COUNT_W        (CW),
    .DEFAULT_PERIOD (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .start     (start),
    .stop      (stop),
    .periodic  (periodic),
    .load_val  (load_val),
    .busy      (busy),
    .done      (done),
    .remaining (remaining)
  );

  initial clk = 1'b0;
  // Free-running clock.
  always #5 clk = ~clk;

  // Edge counter: after the k-th rising edge cyc holds k.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every cycle in which any done bit is high.
  always @(negedge clk) begin
    if (done !== 4'b0000) begin
      obs_q.push_back({32'(cyc), done});
    end
  end

  task automatic step(input logic en);
    enable = en;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic expect_done(input logic [31:0] at, input logic [NCH-1:0] mask);
    exp_q.push_back({at, mask});
  endtask

  task automatic sb_drain(input string tag);
    ev_t o;
    ev_t e;
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_edge"}, o.at, e.at);
      chk({tag, "_mask"}, 32'(o.mask), 32'(e.mask));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [31:0] rem(input int ch);
    return 32'(remaining[ch*CW +: CW]);
  endfunction

  task automatic set_load(input int ch, input logic [CW-1:0] v);
    load_val[ch*CW +: CW] = v;
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    start    = 4'b0000;
    stop     = 4'b0000;
    periodic = 4'b0000;
    load_val = '0;
    step(1'b0);
    step(1'b0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    for (int i = 0; i < NCH; i++) chk("rst_rem", rem(i), 32'd0);
    reset = 1'b0;
    obs_q.delete();

    // 1: one-shot P=3 on ch0
    set_load(0, 24'd3);
    periodic[0] = 1'b0;
    start[0] = 1'b1;
    step(1'b1);
    e0 = 32'(cyc);
    start[0] = 1'b0;
    expect_done(e0 + 32'd3, 4'b0001);
    chk("t1_busy_start", 32'(busy[0]), 32'd1);
    chk("t1_rem_start", rem(0), 32'd2);
    step(1'b1);
    step(1'b1);
    chk("t1_rem_last", rem(0), 32'd0);
    chk("t1_busy_last", 32'(busy[0]), 32'd1);
    step(1'b1);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_busy_end", 32'(busy[0]), 32'd0);
    step(1'b1);
    chk("t1_done_clr", 32'(done), 32'd0);
    chk("t1_rem_end", rem(0), 32'd0);
    sb_drain("t1");

    // 2: periodic P=5 on ch1 with enable every other edge, then stop
    set_load(1, 24'd5);
    periodic[1] = 1'b1;
    start[1] = 1'b1;
    step(1'b1);
    e0 = 32'(cyc);
    start[1] = 1'b0;
    periodic[1] = 1'b0;
    set_load(1, 24'd7);
    expect_done(e0 + 32'd10, 4'b0010);
    expect_done(e0 + 32'd20, 4'b0010);
    for (int i = 1; i <= 21; i++) begin
      step((i % 2) == 0);
      if (i == 15) chk("t2_busy_mid", 32'(busy[1]), 32'd1);
    end
    stop[1] = 1'b1;
    step(1'b1);
    stop[1] = 1'b0;
    chk("t2_busy_stop", 32'(busy[1]), 32'd0);
    chk("t2_rem_stop", rem(1), 32'd0);
    for (int i = 0; i < 12; i++) step(1'b1);
    sb_drain("t2");

    // 3: default period (8) on ch2, retrigger at count 3
    set_load(2, 24'd0);
    start[2] = 1'b1;
    step(1'b1);
    e0 = 32'(cyc);
    start[2] = 1'b0;
    chk("t3_rem_start", rem(2), 32'd7);
    for (int i = 0; i < 4; i++) step(1'b1);
    chk("t3_rem_pre", rem(2), 32'd3);
    start[2] = 1'b1;
    step(1'b1);
    e1 = 32'(cyc);
    start[2] = 1'b0;
    chk("t3_rem_retrig", rem(2), 32'd7);
    expect_done(e1 + 32'd8, 4'b0100);
    for (int i = 0; i < 9; i++) step(1'b1);
    chk("t3_busy_end", 32'(busy[2]), 32'd0);
    sb_drain("t3");

    // 4a: start on the expiry edge of ch3
    set_load(3, 24'd3);
    start[3] = 1'b1;
    step(1'b1);
    e0 = 32'(cyc);
    start[3] = 1'b0;
    step(1'b1);
    step(1'b1);
    set_load(3, 24'd2);
    start[3] = 1'b1;
    step(1'b1);
    start[3] = 1'b0;
    expect_done(e0 + 32'd3, 4'b1000);
    expect_done(e0 + 32'd5, 4'b1000);
    chk("t4_done_coll", 32'(done), 32'd8);
    chk("t4_busy_coll", 32'(busy[3]), 32'd1);
    chk("t4_rem_coll", rem(3), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1);
    chk("t4_busy_end", 32'(busy[3]), 32'd0);
    sb_drain("t4a");

    // 4b: stop on the expiry edge suppresses done
    set_load(3, 24'd2);
    start[3] = 1'b1;
    step(1'b1);
    start[3] = 1'b0;
    step(1'b1);
    chk("t4b_rem_zero", rem(3), 32'd0);
    stop[3] = 1'b1;
    step(1'b1);
    stop[3] = 1'b0;
    chk("t4b_done", 32'(done), 32'd0);
    chk("t4b_busy", 32'(busy[3]), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1);
    sb_drain("t4b");

    // 5a: reset while all channels run
    set_load(0, 24'd10);
    set_load(1, 24'd20);
    set_load(2, 24'd30);
    set_load(3, 24'd40);
    start = 4'b1111;
    step(1'b1);
    start = 4'b0000;
    for (int i = 0; i < 3; i++) step(1'b1);
    chk("t5_busy_run", 32'(busy), 32'd15);
    reset = 1'b1;
    step(1'b1);
    reset = 1'b0;
    chk("t5_busy_rst", 32'(busy), 32'd0);
    chk("t5_done_rst", 32'(done), 32'd0);
    for (int i = 0; i < NCH; i++) chk("t5_rem_rst", rem(i), 32'd0);
    for (int i = 0; i < 12; i++) step(1'b1);
    sb_drain("t5a");

    // 5b: freeze with enable low; start during freeze is ignored
    set_load(0, 24'd6);
    start[0] = 1'b1;
    step(1'b1);
    start[0] = 1'b0;
    step(1'b1);
    step(1'b1);
    chk("t5_rem_pre", rem(0), 32'd3);
    set_load(0, 24'd9);
    start[0] = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b0);
    start[0] = 1'b0;
    chk("t5_rem_frozen", rem(0), 32'd3);
    chk("t5_busy_frozen", 32'(busy[0]), 32'd1);
    e0 = 32'(cyc);
    expect_done(e0 + 32'd4, 4'b0001);
    for (int i = 0; i < 5; i++) step(1'b1);
    sb_drain("t5b");

    // 6a: all channels, same period
    for (int i = 0; i < NCH; i++) set_load(i, 24'd4);
    start = 4'b1111;
    step(1'b1);
    e0 = 32'(cyc);
    start = 4'b0000;
    expect_done(e0 + 32'd4, 4'b1111);
    for (int i = 0; i < 5; i++) step(1'b1);
    sb_drain("t6a");

    // 6b: periods 2/3/4/5 fire on separate edges
    for (int i = 0; i < NCH; i++) set_load(i, CW'(i + 2));
    start = 4'b1111;
    step(1'b1);
    e0 = 32'(cyc);
    start = 4'b0000;
    expect_done(e0 + 32'd2, 4'b0001);
    expect_done(e0 + 32'd3, 4'b0010);
    expect_done(e0 + 32'd4, 4'b0100);
    expect_done(e0 + 32'd5, 4'b1000);
    for (int i = 0; i < 7; i++) step(1'b1);
    chk("t6b_busy_end", 32'(busy), 32'd0);
    sb_drain("t6b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
